// File: rtl/logic_op_pkg.sv
// Shared types for the logic-operation arbiter: opcode and FSM state encodings.
package logic_op_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit bitwise gate evaluator; the reserved opcode yields zero with err set.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = a ^~ b;
            OP_NOT:  y = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among NREQ valid/ready requesters,
// with a single registered response port.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OP_W*NREQ-1:0]  req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_err,
    output logic                  busy
);

    logic [OP_W-1:0]  op_arr [NREQ];
    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[OP_W*g +: OP_W];
        assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
        assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
    end

    state_e           state_q,      state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    op_e              op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [IDW-1:0]   id_q,         id_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q,  resp_data_d;
    logic [IDW-1:0]   resp_id_q,    resp_id_d;
    logic             resp_err_q,   resp_err_d;

    logic             grant_vld_c;
    logic [IDW-1:0]   grant_idx_c;
    logic [WIDTH-1:0] unit_y;
    logic             unit_err;

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (unit_y),
        .err (unit_err)
    );

    // Scan downward from last_grant+NREQ to last_grant+1 so the last hit is the
    // first valid requester above last_grant (last_grant itself has lowest priority).
    always_comb begin
        int idx;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        idx         = 0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (req_valid[IDW'(idx)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    req_ready[grant_idx_c] = 1'b1;
                    last_grant_d           = grant_idx_c;
                    op_d                   = op_e'(op_arr[grant_idx_c]);
                    a_d                    = a_arr[grant_idx_c];
                    b_d                    = b_arr[grant_idx_c];
                    id_d                   = grant_idx_c;
                    state_d                = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d  = unit_y;
                resp_err_d   = unit_err;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            op_q         <= OP_AND;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
